add_rs_dispatch: RTL and testbench
==================================

Name: add_rs_dispatch

Overview:
- Reservation station for the add/sub functional unit in the Tomasulo core.
- Accepts issued add/sub micro-ops and holds them until both operands are valid.
- Captures missing operands by snooping the common data bus (CDB).
- Dispatches one ready entry per cycle to the add/sub execution stage using a registered one-cycle ex_b strobe.

Parameters:
- DEPTH, 3, number of station entries; rs_index width is 3 bits, fixed for DEPTH ≤ 8.
- DW, 8, operand data width.
- TW, 3, ROB tag width.

Ports:
- clk2  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous clear of all entries (mispredict/exception).
- iss_valid  in  1  issue request this cycle.
- iss_ready  out  1  station can accept an issue (not full).
- iss_func  in  4  0000 add, 0001 sub.
- iss_rd  in  4  destination architectural register.
- iss_rob  in  TW  ROB index of this op.
- iss_j_rdy, iss_k_rdy  in  1 each  operand already valid.
- iss_vj, iss_vk  in  DW each  operand values, used when the matching _rdy bit is 1.
- iss_qj, iss_qk  in  TW each  producer ROB tags, used when the matching _rdy bit is 0.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TW  producing ROB index.
- cdb_data  in  DW  broadcast value.
- exec_free  in  1  add/sub exec unit can accept an op this cycle.
- ex_b  out  1  dispatch strobe, one cycle per op.
- rs_index  out  3  dispatched entry index.
- rs1_data, rs2_data  out  DW each  operands.
- func  out  4  dispatched function code.
- rob_ind  out  TW  dispatched ROB index.
- rd  out  4  dispatched destination register.
- add_count  out  2  number of busy entries (0..DEPTH).

Behaviour:
- Reset (async, rst_n=0):
  - all busy bits = 0; ex_b = 0.
  - rs_index, rs1_data, rs2_data, func, rob_ind, rd = 0.
  - add_count = 0; iss_ready = 1.
- Entry state: busy, func, rd, rob, vj, vk, qj, qk, rj, rk.
- Issue:
  - iss_ready = (add_count != DEPTH), derived from registered state only.
  - iss_valid && iss_ready writes the lowest-index non-busy entry at posedge.
  - iss_valid while full is dropped; the issuer must hold the request.
- Same-cycle CDB bypass at issue: if an operand is not ready, cdb_valid=1, and cdb_tag equals its q tag, the entry is written with rj/rk=1 and v=cdb_data.
- CDB wakeup: on cdb_valid, every busy entry with r=0 and q==cdb_tag sets r=1 and v=cdb_data. j and k are handled independently, so both may wake on the same broadcast.
- Select:
  - Combinational from registered state; candidates are busy && rj && rk.
  - Winner is the lowest index (fixed priority).
  - Entries written or woken at edge N are eligible at edge N+1.
- Dispatch:
  - If exec_free && a candidate exists, then at posedge: ex_b=1, output fields loaded from the winner, winner busy cleared.
  - Otherwise ex_b=0 and the data outputs hold their last values.
  - ex_b is high for exactly one cycle per dispatch; back-to-back dispatches on consecutive cycles are legal.
- Minimum latency: issue with both operands ready at edge N gives ex_b high after edge N+1.
- Simultaneous issue and dispatch: a slot freed at edge N is not reusable until edge N+1 (iss_ready uses the pre-edge count). add_count updates by +issue −dispatch.
- Flush: at posedge, clears all busy bits and forces ex_b=0. Flush overrides any issue or dispatch in that cycle.
- Func codes other than 0000/0001 are stored and dispatched unchanged; the exec unit ignores them.
- Tags: CDB tags that match no waiting entry are ignored. A dispatched entry no longer snoops the CDB.

Decomposition:
- Shared package tomasulo_pkg holds:
  - FUNC_ADD=4'b0000, FUNC_SUB=4'b0001.
  - DW, TW, RS_DEPTH constants.
  - a packed rs_entry_t struct (busy, func, rd, rob, vj, vk, qj, qk, rj, rk).
- One sub-module, rs_prio_sel: a DEPTH-bit lowest-index priority encoder that returns a found flag and an index. It is reused for both free-slot selection and ready-entry selection.

Test Plan:
- Ready issue:
  - Stimulus: issue at edge 1 with func=0000, rd=3, rob=2, vj=0x05, vk=0x07, both rdy; exec_free=1.
  - Response: after edge 2, ex_b=1, rs_index=0, rs1_data=0x05, rs2_data=0x07, rob_ind=2, rd=3; add_count 1 then 0.
- CDB wakeup:
  - Stimulus: issue with qj=4 (not ready), vk=0x10. Broadcast cdb_tag=4, data=0x22 at edge 3.
  - Response: ex_b after edge 4 with rs1_data=0x22, rs2_data=0x10. A broadcast with tag 5 leaves the entry waiting.
- Issue bypass: issue qk=1 while cdb_valid=1, cdb_tag=1, data=0x0F in the same cycle -> entry ready at once; dispatch next edge with rs2_data=0x0F.
- Full and priority:
  - Stimulus: issue 3 ready ops with exec_free=0.
  - Response: iss_ready=0 and a 4th issue is dropped. Raising exec_free gives ex_b on 3 consecutive cycles with rs_index 0, 1, 2.
- Flush/reset mid-operation: with 2 busy entries, pulse flush -> add_count=0, ex_b=0 next cycle. Asserting rst_n=0 asynchronously mid-cycle clears ex_b immediately.
- Simultaneous: full station, dispatch at edge N with iss_valid held -> issue accepted at edge N+1 into the freed index.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: function codes, widths and the
// reservation-station entry layout.
package tomasulo_pkg;

  localparam logic [3:0] FUNC_ADD = 4'b0000;
  localparam logic [3:0] FUNC_SUB = 4'b0001;

  localparam int DW       = 8;
  localparam int TW       = 3;
  localparam int RS_DEPTH = 3;

  typedef struct packed {
    logic          busy;
    logic [3:0]    func;
    logic [3:0]    rd;
    logic [TW-1:0] rob;
    logic [DW-1:0] vj;
    logic [DW-1:0] vk;
    logic [TW-1:0] qj;
    logic [TW-1:0] qk;
    logic          rj;
    logic          rk;
  } rs_entry_t;

endpackage

// File: rtl/rs_prio_sel.sv
// Lowest-index-wins priority encoder used for free-slot and ready-entry picks.
module rs_prio_sel #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [2:0]   idx
);

  always_comb begin
    found = |req;
    idx   = '0;
    // Walk downward so the lowest requesting index is the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/add_rs_dispatch.sv
// Add/sub reservation station: holds issued ops, snoops the CDB for missing
// operands and dispatches the lowest-index ready entry once per cycle.
module add_rs_dispatch #(
  parameter int DEPTH = tomasulo_pkg::RS_DEPTH,
  parameter int DW    = tomasulo_pkg::DW,
  parameter int TW    = tomasulo_pkg::TW
) (
  input  logic          clk2,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [3:0]    iss_func,
  input  logic [3:0]    iss_rd,
  input  logic [TW-1:0] iss_rob,
  input  logic          iss_j_rdy,
  input  logic          iss_k_rdy,
  input  logic [DW-1:0] iss_vj,
  input  logic [DW-1:0] iss_vk,
  input  logic [TW-1:0] iss_qj,
  input  logic [TW-1:0] iss_qk,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_tag,
  input  logic [DW-1:0] cdb_data,
  input  logic          exec_free,
  output logic          ex_b,
  output logic [2:0]    rs_index,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic [3:0]    func,
  output logic [TW-1:0] rob_ind,
  output logic [3:0]    rd,
  output logic [1:0]    add_count
);
  import tomasulo_pkg::*;

  rs_entry_t        ent_q [DEPTH];
  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] rdy_vec;
  logic             free_found, rdy_found;
  logic [2:0]       free_idx, rdy_idx;
  logic             do_issue, do_disp;
  rs_entry_t        win;

  logic [1:0]    count_reg, count_next;
  logic          ex_b_reg;
  logic [2:0]    rs_index_reg;
  logic [DW-1:0] rs1_reg, rs2_reg;
  logic [3:0]    func_reg, rd_reg;
  logic [TW-1:0] rob_reg;

  rs_prio_sel #(.N(DEPTH)) u_free_sel (.req(free_vec), .found(free_found), .idx(free_idx));
  rs_prio_sel #(.N(DEPTH)) u_rdy_sel  (.req(rdy_vec),  .found(rdy_found),  .idx(rdy_idx));

  // The slot freed by a dispatch only becomes visible through count_reg next cycle.
  assign iss_ready = (count_reg != 2'(DEPTH));
  assign do_issue  = iss_valid && iss_ready && free_found;
  assign do_disp   = exec_free && rdy_found;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    rs_entry_t ent_reg, ent_next;

    always_comb begin
      ent_next = ent_reg;
      if (flush) begin
        ent_next.busy = 1'b0;
      end else if (do_disp && rdy_idx == 3'(gi)) begin
        ent_next.busy = 1'b0;
      end else if (do_issue && free_idx == 3'(gi)) begin
        ent_next.busy = 1'b1;
        ent_next.func = iss_func;
        ent_next.rd   = iss_rd;
        ent_next.rob  = iss_rob;
        ent_next.qj   = iss_qj;
        ent_next.qk   = iss_qk;
        ent_next.rj   = iss_j_rdy || (cdb_valid && iss_qj == cdb_tag);
        ent_next.rk   = iss_k_rdy || (cdb_valid && iss_qk == cdb_tag);
        ent_next.vj   = (!iss_j_rdy && cdb_valid && iss_qj == cdb_tag) ? cdb_data : iss_vj;
        ent_next.vk   = (!iss_k_rdy && cdb_valid && iss_qk == cdb_tag) ? cdb_data : iss_vk;
      end else if (ent_reg.busy && cdb_valid) begin
        if (!ent_reg.rj && ent_reg.qj == cdb_tag) begin
          ent_next.rj = 1'b1;
          ent_next.vj = cdb_data;
        end
        if (!ent_reg.rk && ent_reg.qk == cdb_tag) begin
          ent_next.rk = 1'b1;
          ent_next.vk = cdb_data;
        end
      end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) ent_reg <= '0;
      else        ent_reg <= ent_next;
    end

    assign ent_q[gi]    = ent_reg;
    assign free_vec[gi] = !ent_reg.busy;
    assign rdy_vec[gi]  = ent_reg.busy && ent_reg.rj && ent_reg.rk;
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy_idx == 3'(i)) win = ent_q[i];
    end
  end

  always_comb begin
    count_next = count_reg + 2'(do_issue) - 2'(do_disp);
    if (flush) count_next = '0;
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= '0;
      ex_b_reg     <= 1'b0;
      rs_index_reg <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      func_reg     <= '0;
      rob_reg      <= '0;
      rd_reg       <= '0;
    end else begin
      count_reg <= count_next;
      ex_b_reg  <= do_disp && !flush;
      if (do_disp && !flush) begin
        rs_index_reg <= rdy_idx;
        rs1_reg      <= win.vj;
        rs2_reg      <= win.vk;
        func_reg     <= win.func;
        rob_reg      <= win.rob;
        rd_reg       <= win.rd;
      end
    end
  end

  assign ex_b      = ex_b_reg;
  assign rs_index  = rs_index_reg;
  assign rs1_data  = rs1_reg;
  assign rs2_data  = rs2_reg;
  assign func      = func_reg;
  assign rob_ind   = rob_reg;
  assign rd        = rd_reg;
  assign add_count = count_reg;

endmodule

// File: tb/tb_add_rs_dispatch.sv
// Bench for add_rs_dispatch: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural station model.
module tb_add_rs_dispatch;

  logic       clk2 = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       iss_valid = 1'b0;
  logic       iss_ready;
  logic [3:0] iss_func = '0, iss_rd = '0;
  logic [2:0] iss_rob = '0, iss_qj = '0, iss_qk = '0;
  logic       iss_j_rdy = 1'b0, iss_k_rdy = 1'b0;
  logic [7:0] iss_vj = '0, iss_vk = '0;
  logic       cdb_valid = 1'b0;
  logic [2:0] cdb_tag = '0;
  logic [7:0] cdb_data = '0;
  logic       exec_free = 1'b0;
  logic       ex_b;
  logic [2:0] rs_index;
  logic [7:0] rs1_data, rs2_data;
  logic [3:0] func, rd;
  logic [2:0] rob_ind;
  logic [1:0] add_count;

  int checks = 0;
  int errors = 0;

  add_rs_dispatch dut (
    .clk2(clk2), .rst_n(rst_n), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_func(iss_func), .iss_rd(iss_rd), .iss_rob(iss_rob),
    .iss_j_rdy(iss_j_rdy), .iss_k_rdy(iss_k_rdy),
    .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_qj(iss_qj), .iss_qk(iss_qk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .exec_free(exec_free), .ex_b(ex_b), .rs_index(rs_index),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .func(func),
    .rob_ind(rob_ind), .rd(rd), .add_count(add_count)
  );

  always #5 clk2 = ~clk2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic set_iss(input logic v, input logic [3:0] fn, input logic [3:0] d,
                         input logic [2:0] rb, input logic jr, input logic [7:0] vj,
                         input logic [2:0] qj, input logic kr, input logic [7:0] vk,
                         input logic [2:0] qk);
    iss_valid = v; iss_func = fn; iss_rd = d; iss_rob = rb;
    iss_j_rdy = jr; iss_vj = vj; iss_qj = qj;
    iss_k_rdy = kr; iss_vk = vk; iss_qk = qk;
  endtask

  task automatic do_reset();
    @(negedge clk2);
    rst_n = 1'b0;
    flush = 1'b0; iss_valid = 1'b0; cdb_valid = 1'b0; exec_free = 1'b0;
    @(negedge clk2);
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string t, input logic eb, input logic [2:0] idx,
                         input logic [7:0] d1, input logic [7:0] d2, input logic [3:0] fn,
                         input logic [2:0] rb, input logic [3:0] d, input logic [1:0] cnt);
    chk({t, ".ex_b"}, 32'(ex_b), 32'(eb));
    chk({t, ".rs_index"}, 32'(rs_index), 32'(idx));
    chk({t, ".rs1"}, 32'(rs1_data), 32'(d1));
    chk({t, ".rs2"}, 32'(rs2_data), 32'(d2));
    chk({t, ".func"}, 32'(func), 32'(fn));
    chk({t, ".rob"}, 32'(rob_ind), 32'(rb));
    chk({t, ".rd"}, 32'(rd), 32'(d));
    chk({t, ".count"}, 32'(add_count), 32'(cnt));
  endtask

  typedef struct {
    logic iv; logic [3:0] fn; logic [3:0] rd; logic [2:0] rob;
    logic jr; logic [7:0] vj; logic [2:0] qj;
    logic kr; logic [7:0] vk; logic [2:0] qk;
    logic cv; logic [2:0] ct; logic [7:0] cd; logic ef;
    logic eb; logic [2:0] eidx; logic [7:0] e1; logic [7:0] e2;
    logic [3:0] efn; logic [2:0] erob; logic [3:0] erd; logic [1:0] ecnt;
  } vec_t;

  vec_t tbl [11];

  typedef struct {
    bit busy; bit [3:0] fn; bit [3:0] rd; bit [2:0] rob;
    bit [7:0] vj; bit [7:0] vk; bit [2:0] qj; bit [2:0] qk; bit rj; bit rk;
  } ment_t;

  ment_t      m [3];
  int         m_cnt;
  logic       x_eb;
  logic [2:0] x_idx, x_rob;
  logic [7:0] x1, x2;
  logic [3:0] x_fn, x_rd;

  // Applies the station's rules for one clock edge using the current inputs.
  task automatic model_edge();
    int w = -1, f = -1;
    bit accept, disp;
    for (int i = 0; i < 3; i++) begin
      if (w < 0 && m[i].busy && m[i].rj && m[i].rk) w = i;
      if (f < 0 && !m[i].busy) f = i;
    end
    accept = iss_valid && (m_cnt < 3);
    disp   = exec_free && (w >= 0);
    if (flush) begin
      for (int i = 0; i < 3; i++) m[i].busy = 0;
      m_cnt = 0;
      x_eb  = 0;
    end else begin
      x_eb = disp;
      if (disp) begin
        x_idx = 3'(w); x1 = m[w].vj; x2 = m[w].vk;
        x_fn = m[w].fn; x_rob = m[w].rob; x_rd = m[w].rd;
        m[w].busy = 0;
      end
      for (int i = 0; i < 3; i++) begin
        if (m[i].busy && cdb_valid) begin
          if (!m[i].rj && m[i].qj == cdb_tag) begin m[i].rj = 1; m[i].vj = cdb_data; end
          if (!m[i].rk && m[i].qk == cdb_tag) begin m[i].rk = 1; m[i].vk = cdb_data; end
        end
      end
      if (accept) begin
        m[f].busy = 1; m[f].fn = iss_func; m[f].rd = iss_rd; m[f].rob = iss_rob;
        m[f].qj = iss_qj; m[f].qk = iss_qk;
        m[f].rj = iss_j_rdy || (cdb_valid && iss_qj == cdb_tag);
        m[f].rk = iss_k_rdy || (cdb_valid && iss_qk == cdb_tag);
        m[f].vj = iss_j_rdy ? iss_vj : cdb_data;
        m[f].vk = iss_k_rdy ? iss_vk : cdb_data;
      end
      m_cnt = m_cnt + int'(accept) - int'(disp);
    end
  endtask

  initial begin
    //            iv fn     rd     rob   jr vj     qj   kr vk     qk   cv ct   cd     ef  eb idx  e1     e2     efn    erob  erd    cnt
    tbl[0]  = '{1, 4'h0, 4'h3, 3'd2, 1, 8'h05, 3'd0, 1, 8'h07, 3'd0, 0, 3'd0, 8'h00, 1,  0, 3'd0, 8'h00, 8'h00, 4'h0, 3'd0, 4'h0, 2'd1};
    tbl[1]  = '{0, 4'h0, 4'h0, 3'd0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 0, 3'd0, 8'h00, 1,  1, 3'd0, 8'h05, 8'h07, 4'h0, 3'd2, 4'h3, 2'd0};
    tbl[2]  = '{1, 4'h1, 4'h5, 3'd3, 0, 8'h00, 3'd4, 1, 8'h10, 3'd0, 0, 3'd0, 8'h00, 1,  0, 3'd0, 8'h05, 8'h07, 4'h0, 3'd2, 4'h3, 2'd1};
    tbl[3]  = '{0, 4'h0, 4'h0, 3'd0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1, 3'd5, 8'h99, 1,  0, 3'd0, 8'h05, 8'h07, 4'h0, 3'd2, 4'h3, 2'd1};
    tbl[4]  = '{0, 4'h0, 4'h0, 3'd0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1, 3'd4, 8'h22, 1,  0, 3'd0, 8'h05, 8'h07, 4'h0, 3'd2, 4'h3, 2'd1};
    tbl[5]  = '{0, 4'h0, 4'h0, 3'd0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 0, 3'd0, 8'h00, 1,  1, 3'd0, 8'h22, 8'h10, 4'h1, 3'd3, 4'h5, 2'd0};
    tbl[6]  = '{1, 4'h0, 4'h7, 3'd6, 1, 8'h30, 3'd0, 0, 8'h00, 3'd1, 1, 3'd1, 8'h0F, 1,  0, 3'd0, 8'h22, 8'h10, 4'h1, 3'd3, 4'h5, 2'd1};
    tbl[7]  = '{0, 4'h0, 4'h0, 3'd0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 0, 3'd0, 8'h00, 1,  1, 3'd0, 8'h30, 8'h0F, 4'h0, 3'd6, 4'h7, 2'd0};
    tbl[8]  = '{1, 4'hA, 4'h2, 3'd1, 0, 8'h00, 3'd7, 0, 8'h00, 3'd7, 0, 3'd0, 8'h00, 1,  0, 3'd0, 8'h30, 8'h0F, 4'h0, 3'd6, 4'h7, 2'd1};
    tbl[9]  = '{0, 4'h0, 4'h0, 3'd0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 1, 3'd7, 8'h5A, 1,  0, 3'd0, 8'h30, 8'h0F, 4'h0, 3'd6, 4'h7, 2'd1};
    tbl[10] = '{0, 4'h0, 4'h0, 3'd0, 0, 8'h00, 3'd0, 0, 8'h00, 3'd0, 0, 3'd0, 8'h00, 1,  1, 3'd0, 8'h5A, 8'h5A, 4'hA, 3'd1, 4'h2, 2'd0};

    do_reset();
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset.iss_ready", 32'(iss_ready), 1);

    for (int v = 0; v < 11; v++) begin
      set_iss(tbl[v].iv, tbl[v].fn, tbl[v].rd, tbl[v].rob, tbl[v].jr, tbl[v].vj, tbl[v].qj,
              tbl[v].kr, tbl[v].vk, tbl[v].qk);
      cdb_valid = tbl[v].cv; cdb_tag = tbl[v].ct; cdb_data = tbl[v].cd;
      exec_free = tbl[v].ef;
      tick();
      $display("vec %0d: ex_b=%0d idx=%0d rs1=%02h rs2=%02h count=%0d",
               v, ex_b, rs_index, rs1_data, rs2_data, add_count);
      chk_out($sformatf("vec%0d", v), tbl[v].eb, tbl[v].eidx, tbl[v].e1, tbl[v].e2,
              tbl[v].efn, tbl[v].erob, tbl[v].erd, tbl[v].ecnt);
    end
    set_iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cdb_valid = 1'b0;

    // Fill with exec stalled, drop a 4th issue, then drain in priority order.
    exec_free = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_iss(1, 4'h0, 4'(i), 3'(i), 1, 8'h10 + 8'(i), 0, 1, 8'h20 + 8'(i), 0);
      tick();
      chk("full.fill_count", 32'(add_count), 32'(i + 1));
    end
    chk("full.iss_ready", 32'(iss_ready), 0);
    set_iss(1, 4'h0, 4'h9, 3'd7, 1, 8'hEE, 0, 1, 8'hEE, 0);
    tick();
    chk("full.drop_count", 32'(add_count), 3);
    iss_valid = 1'b0;
    exec_free = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("drain %0d: ex_b=%0d idx=%0d rob=%0d", i, ex_b, rs_index, rob_ind);
      chk("drain.ex_b", 32'(ex_b), 1);
      chk("drain.idx", 32'(rs_index), 32'(i));
      chk("drain.rob", 32'(rob_ind), 32'(i));
      chk("drain.rs1", 32'(rs1_data), 32'(8'h10 + 8'(i)));
    end
    tick();
    chk("drain.idle_ex_b", 32'(ex_b), 0);
    chk("drain.idle_count", 32'(add_count), 0);

    // Full station, dispatch with issue held: the freed slot is refilled one edge later.
    exec_free = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_iss(1, 4'h1, 4'(i), 3'(i), 1, 8'h40 + 8'(i), 0, 1, 8'h00, 0);
      tick();
    end
    set_iss(1, 4'h0, 4'hC, 3'd5, 1, 8'h55, 0, 1, 8'h66, 0);
    exec_free = 1'b1;
    tick();
    chk("simul.n_idx", 32'(rs_index), 0);
    chk("simul.n_count", 32'(add_count), 2);
    chk("simul.n_ready", 32'(iss_ready), 1);
    tick();
    chk("simul.n1_idx", 32'(rs_index), 1);
    chk("simul.n1_count", 32'(add_count), 2);
    iss_valid = 1'b0;
    tick();
    $display("simul: ex_b=%0d idx=%0d rob=%0d rs1=%02h", ex_b, rs_index, rob_ind, rs1_data);
    chk("simul.n2_idx", 32'(rs_index), 0);
    chk("simul.n2_rob", 32'(rob_ind), 5);
    chk("simul.n2_rs1", 32'(rs1_data), 32'h55);
    tick();
    chk("simul.n3_idx", 32'(rs_index), 2);
    chk("simul.n3_count", 32'(add_count), 0);

    // Flush with two busy entries and exec ready.
    exec_free = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_iss(1, 4'h0, 4'h1, 3'(i), 1, 8'h01, 0, 1, 8'h02, 0);
      tick();
    end
    chk("flush.pre_count", 32'(add_count), 2);
    iss_valid = 1'b0;
    flush = 1'b1;
    exec_free = 1'b1;
    tick();
    $display("flush: ex_b=%0d count=%0d", ex_b, add_count);
    chk("flush.ex_b", 32'(ex_b), 0);
    chk("flush.count", 32'(add_count), 0);
    chk("flush.iss_ready", 32'(iss_ready), 1);
    flush = 1'b0;
    tick();
    chk("flush.after_ex_b", 32'(ex_b), 0);

    // Asynchronous reset while ex_b is high.
    set_iss(1, 4'h0, 4'h4, 3'd3, 1, 8'h77, 0, 1, 8'h88, 0);
    tick();
    iss_valid = 1'b0;
    tick();
    chk("areset.pre_ex_b", 32'(ex_b), 1);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: ex_b=%0d rs1=%02h count=%0d", ex_b, rs1_data, add_count);
    chk("areset.ex_b", 32'(ex_b), 0);
    chk("areset.rs1", 32'(rs1_data), 0);
    chk("areset.count", 32'(add_count), 0);
    @(negedge clk2);
    rst_n = 1'b1;

    // Randomized run against the behavioural model from a clean reset.
    do_reset();
    for (int i = 0; i < 3; i++) m[i] = '{default: 0};
    m_cnt = 0; x_eb = 0; x_idx = 0; x1 = 0; x2 = 0; x_fn = 0; x_rob = 0; x_rd = 0;
    for (int c = 0; c < 400; c++) begin
      set_iss(1'($urandom_range(0, 9) < 6), 4'($urandom), 4'($urandom), 3'($urandom),
              1'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 8'($urandom),
              3'($urandom));
      cdb_valid = 1'($urandom);
      cdb_tag   = 3'($urandom);
      cdb_data  = 8'($urandom);
      exec_free = 1'($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 31) == 0);
      chk("rand.iss_ready", 32'(iss_ready), 32'(m_cnt < 3));
      model_edge();
      tick();
      if (ex_b)
        $display("rand %0d: dispatch idx=%0d rob=%0d rs1=%02h rs2=%02h",
                 c, rs_index, rob_ind, rs1_data, rs2_data);
      chk_out("rand", x_eb, x_idx, x1, x2, x_fn, x_rob, x_rd, 2'(m_cnt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
